// File: rtl/vga_syncgen_pkg.sv
// vga_syncgen_pkg: shared 640x480@60 raster timing constants and axis phase encoding
package vga_syncgen_pkg;
   localparam int H_FRONT         = 16;
   localparam int H_WIDTH         = 96;
   localparam int H_BACK          = 48;
   localparam int H_BRANK         = H_FRONT + H_WIDTH + H_BACK;
   localparam int H_SYNC_INTERVAL = 800;
   localparam int V_FRONT         = 10;
   localparam int V_WIDTH         = 2;
   localparam int V_BACK          = 33;
   localparam int V_BRANK         = V_FRONT + V_WIDTH + V_BACK;
   localparam int V_SYNC_INTERVAL = 525;
   typedef enum logic [1:0] {
      PH_FRONT  = 2'd0,
      PH_SYNC   = 2'd1,
      PH_BACK   = 2'd2,
      PH_ACTIVE = 2'd3
   } phase_t;
endpackage

// File: rtl/vga_syncgen_axis.sv
// vga_syncgen_axis: one raster axis, a wrapping counter plus its front/sync/back/active phase FSM
module vga_syncgen_axis
   import vga_syncgen_pkg::*;
#(
   parameter int FRONT    = 16,
   parameter int WIDTH    = 96,
   parameter int BACK     = 48,
   parameter int INTERVAL = 800
)(
   input  logic       PCK,
   input  logic       RST,
   input  logic       tick,
   output logic [9:0] cnt,
   output logic [1:0] phase,
   output logic       wrap
);
   localparam logic [9:0] LAST  = 10'(INTERVAL - 1);
   localparam logic [9:0] F_END = 10'(FRONT - 1);
   localparam logic [9:0] W_END = 10'(WIDTH - 1);
   localparam logic [9:0] B_END = 10'(BACK - 1);
   phase_t     state;
   logic [9:0] pcnt;
   assign wrap  = tick && cnt == LAST;
   assign phase = state;
   // counter and phase advance together on each tick; the phase counter restarts on every transition
   always_ff @(posedge PCK) begin
      if (RST) begin
         cnt   <= '0;
         pcnt  <= '0;
         state <= PH_FRONT;
      end else if (tick) begin
         cnt  <= wrap ? '0 : cnt + 10'd1;
         pcnt <= pcnt + 10'd1;
         case (state)
            PH_FRONT:  if (pcnt == F_END) begin state <= PH_SYNC;   pcnt <= '0; end
            PH_SYNC:   if (pcnt == W_END) begin state <= PH_BACK;   pcnt <= '0; end
            PH_BACK:   if (pcnt == B_END) begin state <= PH_ACTIVE; pcnt <= '0; end
            default:   if (wrap)          begin state <= PH_FRONT;  pcnt <= '0; end
         endcase
      end
   end
endmodule

// File: rtl/vga_syncgen.sv
// vga_syncgen: VGA raster timing generator; define VGA_SYNCGEN_FRAMECNT_EN to add the FRAME_CNT output
module vga_syncgen
   import vga_syncgen_pkg::*;
#(
   parameter int H_FRONT         = vga_syncgen_pkg::H_FRONT,
   parameter int H_WIDTH         = vga_syncgen_pkg::H_WIDTH,
   parameter int H_BACK          = vga_syncgen_pkg::H_BACK,
   parameter int H_SYNC_INTERVAL = vga_syncgen_pkg::H_SYNC_INTERVAL,
   parameter int V_FRONT         = vga_syncgen_pkg::V_FRONT,
   parameter int V_WIDTH         = vga_syncgen_pkg::V_WIDTH,
   parameter int V_BACK          = vga_syncgen_pkg::V_BACK,
   parameter int V_SYNC_INTERVAL = vga_syncgen_pkg::V_SYNC_INTERVAL
)(
   input  logic       PCK,
   input  logic       RST,
   output logic [9:0] HCNT,
   output logic [9:0] VCNT,
   output logic       VGA_HS,
   output logic       VGA_VS,
   output logic       VGA_DE,
   output logic       FRAME_START
`ifdef VGA_SYNCGEN_FRAMECNT_EN
   ,
   output logic [7:0] FRAME_CNT
`endif
);
   localparam logic [9:0] H_FIRST = 10'(H_FRONT + H_WIDTH + H_BACK);
   localparam logic [9:0] V_FIRST = 10'(V_FRONT + V_WIDTH + V_BACK);
   logic [1:0] h_phase;
   logic [1:0] v_phase;
   logic       h_end;
   logic       first_px;
   assign first_px = HCNT == H_FIRST && VCNT == V_FIRST;
   vga_syncgen_axis #(
      .FRONT(H_FRONT), .WIDTH(H_WIDTH), .BACK(H_BACK), .INTERVAL(H_SYNC_INTERVAL)
   ) u_h (
      .PCK(PCK), .RST(RST), .tick(1'b1), .cnt(HCNT), .phase(h_phase), .wrap(h_end)
   );
   vga_syncgen_axis #(
      .FRONT(V_FRONT), .WIDTH(V_WIDTH), .BACK(V_BACK), .INTERVAL(V_SYNC_INTERVAL)
   ) u_v (
      .PCK(PCK), .RST(RST), .tick(h_end), .cnt(VCNT), .phase(v_phase), .wrap()
   );
   // sync, enable and strobe are decoded one stage behind the counters to align with registered RGB
   always_ff @(posedge PCK) begin
      if (RST) begin
         VGA_HS      <= 1'b1;
         VGA_VS      <= 1'b1;
         VGA_DE      <= 1'b0;
         FRAME_START <= 1'b0;
      end else begin
         VGA_HS      <= h_phase != PH_SYNC;
         VGA_VS      <= v_phase != PH_SYNC;
         VGA_DE      <= h_phase == PH_ACTIVE && v_phase == PH_ACTIVE;
         FRAME_START <= first_px;
      end
   end
`ifdef VGA_SYNCGEN_FRAMECNT_EN
   // frame counter steps on the same edge that raises FRAME_START
   always_ff @(posedge PCK) begin
      if (RST) FRAME_CNT <= '0;
      else if (first_px) FRAME_CNT <= FRAME_CNT + 8'd1;
   end
`endif
endmodule
